maj_vec_checker: RTL and testbench
==================================

MAJ_VEC_CHECKER -- requirements
Module: maj_vec_checker

Interface
REQ-001 Parameter N, default 33: DUT input width (number of majority inputs); SHALL be odd, 3..33.
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before sampling; SHALL be >= 1.
REQ-003 Parameter CW, default 32: mismatch counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a sweep when not busy.
REQ-007 vec_limit  in  N+1  number of vectors to apply; 0 means full 2^N sweep; sampled on accepted start.
REQ-008 x  out  N  vector driven to the combinational majority DUT (bit i to DUT input xi).
REQ-009 y_dut  in  1  DUT majority output (y0).
REQ-010 busy  out  1  high while a sweep is in progress.
REQ-011 done  out  1  high from sweep completion until next accepted start or reset.
REQ-012 mismatch_cnt  out  CW  count of vectors where y_dut differed from reference.
REQ-013 first_fail  out  N  first failing vector; first_fail_vld  out  1  marks it valid.

Function
REQ-014 Reference SHALL be y_ref = (popcount(x) >= (N+1)/2), computed combinationally from the registered x.
REQ-015 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE/DONE + start: SHALL clear mismatch_cnt, first_fail, first_fail_vld, done; load x=0, latch limit; go to DRIVE.
REQ-017 DRIVE SHALL hold x stable for exactly SETTLE cycles, then go to SAMPLE.
REQ-018 SAMPLE SHALL compare y_dut against y_ref for current x (one cycle); on mismatch increment mismatch_cnt, saturating at 2^CW-1.
REQ-019 First mismatch of a sweep SHALL load first_fail=x and set first_fail_vld; later mismatches SHALL not alter them.
REQ-020 SAMPLE with x == limit-1 (limit 0 treated as 2^N, i.e. x all-ones) SHALL go to DONE; otherwise x increments by 1 and goes to DRIVE.
REQ-021 Each vector SHALL cost exactly SETTLE+1 cycles; done SHALL assert exactly vec_limit*(SETTLE+1)+1 cycles after the start edge.
REQ-022 x SHALL never wrap; the all-ones vector is the last of a full sweep; index counter SHALL be N+1 bits.
REQ-023 start while busy SHALL be ignored.
REQ-024 DONE SHALL hold x, mismatch_cnt, first_fail values; busy=0, done=1.
REQ-025 busy SHALL be 1 exactly in DRIVE and SAMPLE.

Reset
REQ-026 rst SHALL force IDLE and x=0, busy=0, done=0, mismatch_cnt=0, first_fail=0, first_fail_vld=0 on the next edge, including mid-sweep; rst dominates start.

Structure
REQ-027 Package maj_pkg SHALL hold the FSM state enum and the threshold function THRESH(N)=(N+1)/2.
REQ-028 Sub-module maj_popcount (N-bit in, $clog2(N+1)-bit count out, combinational) SHALL provide the reference count.
REQ-029 Block is synthesizable; no delays, no X-handling logic.

Verification
REQ-030 N=5, SETTLE=1, golden majority DUT, vec_limit=0 -> 32 vectors, done at 65 cycles after start, mismatch_cnt=0, first_fail_vld=0.
REQ-031 N=5, DUT stuck-at-0, vec_limit=0 -> mismatch_cnt=16, first_fail=5'b00111.
REQ-032 N=5, DUT stuck-at-1 -> mismatch_cnt=16, first_fail=5'b00000; second start reclears and repeats same results.
REQ-033 N=33, SETTLE=2, golden DUT, vec_limit=10 -> done after 31 cycles, final x=9, mismatch_cnt=0.
REQ-034 N=5, rst asserted during vector 12 -> next cycle all outputs zero, state IDLE; start pulse during busy produces no restart.

Source files
------------

// File: rtl/maj_vec_checker_pkg.sv
// maj_pkg: FSM state encoding and majority threshold shared by the vector checker.
package maj_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    function automatic int thresh(input int n);
        return (n + 1) / 2;
    endfunction
endpackage

// File: rtl/maj_vec_checker_if.sv
// maj_vec_checker_if: sweep control, DUT stimulus/response and result signals.
interface maj_vec_checker_if #(parameter int N = 33, parameter int CW = 32);
    logic          start;
    logic [N:0]    vec_limit;
    logic [N-1:0]  x;
    logic          y_dut;
    logic          busy;
    logic          done;
    logic [CW-1:0] mismatch_cnt;
    logic [N-1:0]  first_fail;
    logic          first_fail_vld;
    modport master (output start, vec_limit, y_dut,
                    input  x, busy, done, mismatch_cnt, first_fail, first_fail_vld);
    modport slave  (input  start, vec_limit, y_dut,
                    output x, busy, done, mismatch_cnt, first_fail, first_fail_vld);
endinterface

// File: rtl/maj_vec_checker_popcount.sv
// maj_popcount: combinational population count of an N-bit vector.
module maj_popcount #(
    parameter int N = 33,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] in_vec,
    output logic [W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + W'(in_vec[i]);
    end
endmodule

// File: rtl/maj_vec_checker.sv
// maj_vec_checker: sweeps vectors into a combinational majority DUT and
// compares its output against a popcount-based reference.
module maj_vec_checker
    import maj_pkg::*;
#(
    parameter int N      = 33,
    parameter int SETTLE = 1,
    parameter int CW     = 32
) (
    input logic             clk,
    input logic             rst,
    maj_vec_checker_if.slave bus
);
    localparam int PW = $clog2(N + 1);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [N:0] one = (N + 1)'(1);

    state_t        state_q, state_d;
    logic [N:0]    idx_q, idx_d;
    logic [N:0]    lim_q, lim_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] mm_cnt_q, mm_cnt_d;
    logic [N-1:0]  ff_q, ff_d;
    logic          ff_vld_q, ff_vld_d;
    logic [PW-1:0] pop;
    logic [N:0]    last_idx;
    logic          y_ref, mism;

    maj_popcount #(.N(N), .W(PW)) u_pop (.in_vec(idx_q[N-1:0]), .cnt(pop));

    assign y_ref    = pop >= PW'(thresh(N));
    assign mism     = bus.y_dut != y_ref;
    // A zero limit means the full 2^N sweep, ending on the all-ones vector.
    assign last_idx = (lim_q == '0) ? {1'b0, {N{1'b1}}} : lim_q - one;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lim_d    = lim_q;
        settle_d = settle_q;
        mm_cnt_d = mm_cnt_q;
        ff_d     = ff_q;
        ff_vld_d = ff_vld_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d  = DRIVE;
                idx_d    = '0;
                lim_d    = bus.vec_limit;
                settle_d = '0;
                mm_cnt_d = '0;
                ff_d     = '0;
                ff_vld_d = 1'b0;
            end
            DRIVE: begin
                settle_d = (settle_q == SW'(SETTLE - 1)) ? '0 : settle_q + SW'(1);
                state_d  = (settle_q == SW'(SETTLE - 1)) ? SAMPLE : DRIVE;
            end
            SAMPLE: begin
                mm_cnt_d = (mism && !(&mm_cnt_q)) ? mm_cnt_q + CW'(1) : mm_cnt_q;
                ff_d     = (mism && !ff_vld_q) ? idx_q[N-1:0] : ff_q;
                ff_vld_d = ff_vld_q | mism;
                state_d  = (idx_q == last_idx) ? DONE : DRIVE;
                idx_d    = (idx_q == last_idx) ? idx_q : idx_q + one;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            lim_q    <= '0;
            settle_q <= '0;
            mm_cnt_q <= '0;
            ff_q     <= '0;
            ff_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lim_q    <= lim_d;
            settle_q <= settle_d;
            mm_cnt_q <= mm_cnt_d;
            ff_q     <= ff_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign bus.x              = idx_q[N-1:0];
    assign bus.busy           = (state_q == DRIVE) || (state_q == SAMPLE);
    assign bus.done           = state_q == DONE;
    assign bus.mismatch_cnt   = mm_cnt_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ff_vld_q;
endmodule

// File: tb/tb_maj_vec_checker.sv
// tb_maj_vec_checker: directed scenarios on three checker configurations
// driving behavioural majority DUTs (golden, stuck-at-0, stuck-at-1).
module tb_maj_vec_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [1:0] mode_a = 2'd0;
    logic [1:0] mode_c = 2'd0;

    always #5 clk = ~clk;

    maj_vec_checker_if #(.N(5),  .CW(32)) a_if ();
    maj_vec_checker_if #(.N(33), .CW(32)) b_if ();
    maj_vec_checker_if #(.N(3),  .CW(2))  c_if ();

    assign a_if.y_dut = (mode_a == 2'd0) ? ($countones(a_if.x) >= 3) : (mode_a == 2'd2);
    assign b_if.y_dut = $countones(b_if.x) >= 17;
    assign c_if.y_dut = (mode_c == 2'd0) ? ($countones(c_if.x) >= 2) : (mode_c == 2'd2);

    maj_vec_checker #(.N(5),  .SETTLE(1), .CW(32)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    maj_vec_checker #(.N(33), .SETTLE(2), .CW(32)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    maj_vec_checker #(.N(3),  .SETTLE(3), .CW(2))  dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

    task automatic pulse_a(input logic [5:0] lim);
        @(posedge clk); #1;
        a_if.start = 1'b1;
        a_if.vec_limit = lim;
        @(posedge clk); #1;
        a_if.start = 1'b0;
    endtask

    task automatic wait_a(output int cyc);
        cyc = 1;
        while (!a_if.done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_if.x !== 5'd0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_a_ctl x=%0d busy=%b done=%b exp 0/0/0", a_if.x, a_if.busy, a_if.done);
        end
        checks++;
        if (a_if.mismatch_cnt !== 32'd0 || a_if.first_fail !== 5'd0 || a_if.first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_a_res cnt=%0d ff=%0d vld=%b exp 0/0/0", a_if.mismatch_cnt, a_if.first_fail, a_if.first_fail_vld);
        end
        checks++;
        if (b_if.busy !== 1'b0 || b_if.done !== 1'b0 || c_if.busy !== 1'b0 || c_if.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_bc b=%b%b c=%b%b exp 00 00", b_if.busy, b_if.done, c_if.busy, c_if.done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_golden_full;
        int cyc;
        mode_a = 2'd0;
        pulse_a(6'd0);
        checks++;
        if (a_if.busy !== 1'b1 || a_if.x !== 5'd0) begin
            failures++;
            $display("FAIL golden_start busy=%b x=%0d exp 1/0", a_if.busy, a_if.x);
        end
        wait_a(cyc);
        checks++;
        if (cyc !== 65) begin
            failures++;
            $display("FAIL golden_latency got=%0d exp=65", cyc);
        end
        checks++;
        if (a_if.mismatch_cnt !== 32'd0 || a_if.first_fail_vld !== 1'b0 || a_if.x !== 5'd31 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL golden_result cnt=%0d vld=%b x=%0d busy=%b exp 0/0/31/0", a_if.mismatch_cnt, a_if.first_fail_vld, a_if.x, a_if.busy);
        end
    endtask

    task automatic test_stuck0;
        int cyc;
        mode_a = 2'd1;
        pulse_a(6'd0);
        wait_a(cyc);
        checks++;
        if (a_if.mismatch_cnt !== 32'd16) begin
            failures++;
            $display("FAIL stuck0_cnt got=%0d exp=16", a_if.mismatch_cnt);
        end
        checks++;
        if (a_if.first_fail !== 5'b00111 || a_if.first_fail_vld !== 1'b1) begin
            failures++;
            $display("FAIL stuck0_first got=%b vld=%b exp 00111/1", a_if.first_fail, a_if.first_fail_vld);
        end
    endtask

    task automatic test_stuck1_restart;
        int cyc;
        mode_a = 2'd2;
        for (int r = 0; r < 2; r++) begin
            pulse_a(6'd0);
            checks++;
            if (a_if.mismatch_cnt !== 32'd0 || a_if.first_fail_vld !== 1'b0 || a_if.done !== 1'b0) begin
                failures++;
                $display("FAIL stuck1_clear run=%0d cnt=%0d vld=%b done=%b exp 0/0/0", r, a_if.mismatch_cnt, a_if.first_fail_vld, a_if.done);
            end
            wait_a(cyc);
            checks++;
            if (cyc !== 65 || a_if.mismatch_cnt !== 32'd16 || a_if.first_fail !== 5'd0 || a_if.first_fail_vld !== 1'b1) begin
                failures++;
                $display("FAIL stuck1_result run=%0d cyc=%0d cnt=%0d ff=%0d vld=%b exp 65/16/0/1", r, cyc, a_if.mismatch_cnt, a_if.first_fail, a_if.first_fail_vld);
            end
        end
    endtask

    task automatic test_limits;
        int cyc;
        logic [5:0] lims [3] = '{6'd1, 6'd3, 6'd32};
        int exp_cyc [3] = '{3, 7, 65};
        logic [4:0] exp_x [3] = '{5'd0, 5'd2, 5'd31};
        mode_a = 2'd0;
        for (int i = 0; i < 3; i++) begin
            pulse_a(lims[i]);
            wait_a(cyc);
            checks++;
            if (cyc !== exp_cyc[i] || a_if.x !== exp_x[i]) begin
                failures++;
                $display("FAIL limit_%0d cyc=%0d x=%0d exp %0d/%0d", lims[i], cyc, a_if.x, exp_cyc[i], exp_x[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        int k = 0;
        mode_a = 2'd1;
        pulse_a(6'd0);
        while (a_if.x != 5'd10 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        a_if.start = 1'b1;
        a_if.vec_limit = 6'd2;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        a_if.vec_limit = 6'd0;
        checks++;
        if (a_if.busy !== 1'b1 || a_if.x < 5'd10) begin
            failures++;
            $display("FAIL busy_ignore busy=%b x=%0d exp busy=1 x>=10", a_if.busy, a_if.x);
        end
        wait_a(cyc);
        checks++;
        if (a_if.mismatch_cnt !== 32'd16 || a_if.x !== 5'd31 || a_if.first_fail !== 5'b00111) begin
            failures++;
            $display("FAIL busy_result cnt=%0d x=%0d ff=%b exp 16/31/00111", a_if.mismatch_cnt, a_if.x, a_if.first_fail);
        end
    endtask

    task automatic test_mid_reset;
        int k = 0;
        mode_a = 2'd2;
        pulse_a(6'd0);
        while (a_if.x != 5'd12 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (a_if.x !== 5'd12 || a_if.first_fail_vld !== 1'b1) begin
            failures++;
            $display("FAIL midrst_reach x=%0d vld=%b exp 12/1", a_if.x, a_if.first_fail_vld);
        end
        rst = 1'b1;
        a_if.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_if.start = 1'b0;
        checks++;
        if (a_if.x !== 5'd0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0 || a_if.mismatch_cnt !== 32'd0 || a_if.first_fail !== 5'd0 || a_if.first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear x=%0d busy=%b done=%b cnt=%0d ff=%0d vld=%b exp all 0", a_if.x, a_if.busy, a_if.done, a_if.mismatch_cnt, a_if.first_fail, a_if.first_fail_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle busy=%b done=%b exp 0/0", a_if.busy, a_if.done);
        end
    endtask

    task automatic test_n33_limit;
        int cyc = 1;
        @(posedge clk); #1;
        b_if.start = 1'b1;
        b_if.vec_limit = 34'd10;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        while (!b_if.done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 31) begin
            failures++;
            $display("FAIL n33_latency got=%0d exp=31", cyc);
        end
        checks++;
        if (b_if.x !== 33'd9 || b_if.mismatch_cnt !== 32'd0 || b_if.first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL n33_result x=%0d cnt=%0d vld=%b exp 9/0/0", b_if.x, b_if.mismatch_cnt, b_if.first_fail_vld);
        end
    endtask

    task automatic test_saturate;
        int cyc = 1;
        mode_c = 2'd2;
        @(posedge clk); #1;
        c_if.start = 1'b1;
        c_if.vec_limit = 4'd0;
        @(posedge clk); #1;
        c_if.start = 1'b0;
        while (!c_if.done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 33 || c_if.x !== 3'd7) begin
            failures++;
            $display("FAIL sat_latency cyc=%0d x=%0d exp 33/7", cyc, c_if.x);
        end
        checks++;
        if (c_if.mismatch_cnt !== 2'd3 || c_if.first_fail !== 3'd0 || c_if.first_fail_vld !== 1'b1) begin
            failures++;
            $display("FAIL sat_result cnt=%0d ff=%0d vld=%b exp 3/0/1", c_if.mismatch_cnt, c_if.first_fail, c_if.first_fail_vld);
        end
    endtask

    initial begin
        a_if.start = 1'b0;
        a_if.vec_limit = '0;
        b_if.start = 1'b0;
        b_if.vec_limit = '0;
        c_if.start = 1'b0;
        c_if.vec_limit = '0;
        test_reset;
        test_golden_full;
        test_stuck0;
        test_stuck1_restart;
        test_limits;
        test_start_while_busy;
        test_mid_reset;
        test_n33_limit;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
